// File: rtl/led_pkg.sv
// Shared encodings for the LED flow sequencer: display modes, per-mode
// entry patterns and bounce end markers.
package led_pkg;

   localparam int LED_W = 4;

   typedef enum logic [1:0] {
      MODE_SHIFT_L = 2'd0,
      MODE_SHIFT_R = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BOUNCE  = 2'd3
   } mode_t;

   localparam logic [LED_W-1:0] INIT_SHIFT_L = 4'b0001;
   localparam logic [LED_W-1:0] INIT_SHIFT_R = 4'b1000;
   localparam logic [LED_W-1:0] INIT_BLINK   = 4'b1111;
   localparam logic [LED_W-1:0] INIT_BOUNCE  = 4'b0001;

   localparam logic [LED_W-1:0] BOUNCE_LEFT_END  = 4'b1000;
   localparam logic [LED_W-1:0] BOUNCE_RIGHT_END = 4'b0001;

   function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
      logic [LED_W-1:0] p;
      case (m)
         MODE_SHIFT_L: p = INIT_SHIFT_L;
         MODE_SHIFT_R: p = INIT_SHIFT_R;
         MODE_BLINK:   p = INIT_BLINK;
         MODE_BOUNCE:  p = INIT_BOUNCE;
         default:      p = INIT_SHIFT_L;
      endcase
      return p;
   endfunction

   function automatic mode_t mode_succ(input mode_t m);
      mode_t n;
      case (m)
         MODE_SHIFT_L: n = MODE_SHIFT_R;
         MODE_SHIFT_R: n = MODE_BLINK;
         MODE_BLINK:   n = MODE_BOUNCE;
         MODE_BOUNCE:  n = MODE_SHIFT_L;
         default:      n = MODE_SHIFT_L;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts sys_clk edges and strobes tc on the last cycle of
// each period P = TICK_CYCLES >> speed. Holds while paused.
module tick_gen #(
   parameter int TICK_CYCLES = 25_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       clear,
   input  logic       pause,
   input  logic [1:0] speed,
   output logic       tc
);

   localparam int CW = $clog2(TICK_CYCLES);

   logic [CW-1:0] cnt;
   logic [CW-1:0] term;

   // P-1 never exceeds TICK_CYCLES-1, so it always fits in CW bits
   assign term = CW'((TICK_CYCLES >> speed) - 1);
   assign tc   = !pause && (cnt == term);

   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) begin
         cnt <= '0;
      end else if (!pause) begin
         if (tc) cnt <= '0;
         else    cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED bank pattern sequencer: mode FSM, speed register and pattern register,
// paced by the tick_gen prescaler.
//
// state        | meaning
// MODE_SHIFT_L | single lit LED rotating left
// MODE_SHIFT_R | single lit LED rotating right
// MODE_BLINK   | whole bank toggling on/off
// MODE_BOUNCE  | single LED walking to each end and back
module led_flow_ctrl
   import led_pkg::*;
#(
   parameter int TICK_CYCLES = 25_000_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             mode_next,
   input  logic             speed_up,
   input  logic             speed_down,
   input  logic             pause,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic [1:0]       speed,
   output logic             tick
);

   mode_t            state_q;
   mode_t            state_d;
   logic [1:0]       speed_q;
   logic [1:0]       speed_d;
   logic             speed_chg;
   logic             tc;
   logic [LED_W-1:0] led_d;
   logic             dir_right;
   logic             dir_d;
   logic             tick_d;

   always_comb begin
      speed_d = speed_q;
      if (speed_up && !speed_down && speed_q != 2'd3)
         speed_d = speed_q + 2'd1;
      else if (speed_down && !speed_up && speed_q != 2'd0)
         speed_d = speed_q - 2'd1;
      speed_chg = (speed_d != speed_q);
   end

   tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_gen (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clear   (mode_next || speed_chg),
      .pause   (pause),
      .speed   (speed_q),
      .tc      (tc)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= MODE_SHIFT_L;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (mode_next) state_d = mode_succ(state_q);
   end

   // A mode change or speed change discards a coincident terminal count
   always_comb begin
      led_d  = led;
      dir_d  = dir_right;
      tick_d = 1'b0;
      if (mode_next) begin
         led_d = init_pattern(state_d);
         dir_d = 1'b0;
      end else if (tc && !speed_chg) begin
         tick_d = 1'b1;
         case (state_q)
            MODE_SHIFT_L: led_d = {led[LED_W-2:0], led[LED_W-1]};
            MODE_SHIFT_R: led_d = {led[0], led[LED_W-1:1]};
            MODE_BLINK:   led_d = ~led;
            MODE_BOUNCE: begin
               if (!dir_right) begin
                  led_d = {led[LED_W-2:0], 1'b0};
                  if (led_d == BOUNCE_LEFT_END) dir_d = 1'b1;
               end else begin
                  led_d = {1'b0, led[LED_W-1:1]};
                  if (led_d == BOUNCE_RIGHT_END) dir_d = 1'b0;
               end
            end
            default: led_d = led;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         speed_q   <= 2'd0;
         led       <= INIT_SHIFT_L;
         dir_right <= 1'b0;
         tick      <= 1'b0;
      end else begin
         speed_q   <= speed_d;
         led       <= led_d;
         dir_right <= dir_d;
         tick      <= tick_d;
      end
   end

   assign mode  = state_q;
   assign speed = speed_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with TICK_CYCLES=16 (P = 16/8/4/2).
module tb_led_flow_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       mode_next = 1'b0;
   logic       speed_up = 1'b0;
   logic       speed_down = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       tick;

   int total = 0;
   int bad   = 0;

   led_flow_ctrl #(.TICK_CYCLES(16)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .mode_next  (mode_next),
      .speed_up   (speed_up),
      .speed_down (speed_down),
      .pause      (pause),
      .led        (led),
      .mode       (mode),
      .speed      (speed),
      .tick       (tick)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   logic [3:0] bexp [7];

   initial begin
      bexp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

      // reset release
      cyc(2);
      chk("rst_led", {4'b0, led}, 8'h01);
      chk("rst_mode", {6'b0, mode}, 8'h00);
      chk("rst_speed", {6'b0, speed}, 8'h00);
      chk("rst_tick", {7'b0, tick}, 8'h00);
      sys_rst = 1'b0;
      cyc(15);
      chk("first_hold_led", {4'b0, led}, 8'h01);
      chk("first_hold_tick", {7'b0, tick}, 8'h00);
      cyc(1);
      chk("step1_led", {4'b0, led}, 8'h02);
      chk("step1_tick", {7'b0, tick}, 8'h01);
      cyc(1);
      chk("step1_tick_low", {7'b0, tick}, 8'h00);
      cyc(15);
      chk("step2_led", {4'b0, led}, 8'h04);
      chk("step2_tick", {7'b0, tick}, 8'h01);
      cyc(16);
      chk("step3_led", {4'b0, led}, 8'h08);
      cyc(15);
      chk("step4_pre", {4'b0, led}, 8'h08);
      cyc(1);
      chk("step4_wrap", {4'b0, led}, 8'h01);

      // mode cycling
      mode_next = 1'b1; cyc(1); mode_next = 1'b0;
      chk("m1_mode", {6'b0, mode}, 8'h01);
      chk("m1_led", {4'b0, led}, 8'h08);
      chk("m1_tick", {7'b0, tick}, 8'h00);
      cyc(15);
      chk("m1_hold", {4'b0, led}, 8'h08);
      cyc(1);
      chk("m1_step", {4'b0, led}, 8'h04);
      mode_next = 1'b1; cyc(1); mode_next = 1'b0;
      chk("m2_mode", {6'b0, mode}, 8'h02);
      chk("m2_led", {4'b0, led}, 8'h0f);
      cyc(16);
      chk("m2_step", {4'b0, led}, 8'h00);
      chk("m2_tick", {7'b0, tick}, 8'h01);
      mode_next = 1'b1; cyc(1); mode_next = 1'b0;
      chk("m3_mode", {6'b0, mode}, 8'h03);
      chk("m3_led", {4'b0, led}, 8'h01);

      // bounce
      for (int i = 0; i < 7; i++) begin
         cyc(16);
         chk($sformatf("bounce%0d_led", i), {4'b0, led}, {4'b0, bexp[i]});
         chk($sformatf("bounce%0d_tick", i), {7'b0, tick}, 8'h01);
      end

      // speed saturation upward: P=2 after the third change
      speed_up = 1'b1; cyc(4); speed_up = 1'b0;
      chk("sat_up_speed", {6'b0, speed}, 8'h03);
      chk("sat_up_tick", {7'b0, tick}, 8'h00);
      cyc(1);
      chk("fast1_tick", {7'b0, tick}, 8'h01);
      chk("fast1_led", {4'b0, led}, 8'h04);
      cyc(1);
      chk("fast_gap_tick", {7'b0, tick}, 8'h00);
      cyc(1);
      chk("fast2_led", {4'b0, led}, 8'h08);
      speed_up = 1'b1; speed_down = 1'b1; cyc(1);
      speed_up = 1'b0; speed_down = 1'b0;
      chk("both_speed", {6'b0, speed}, 8'h03);
      cyc(1);
      chk("both_noclr_tick", {7'b0, tick}, 8'h01);
      chk("both_noclr_led", {4'b0, led}, 8'h04);

      // speed saturation downward
      speed_down = 1'b1; cyc(5); speed_down = 1'b0;
      chk("sat_dn_speed", {6'b0, speed}, 8'h00);
      chk("sat_dn_tick", {7'b0, tick}, 8'h00);

      // pause at cnt=5 for 10 cycles
      cyc(3);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk($sformatf("pause%0d_tick", i), {7'b0, tick}, 8'h00);
      end
      chk("pause_led_held", {4'b0, led}, 8'h04);
      pause = 1'b0;
      cyc(10);
      chk("resume_pre_tick", {7'b0, tick}, 8'h00);
      cyc(1);
      chk("resume_tick", {7'b0, tick}, 8'h01);
      chk("resume_led", {4'b0, led}, 8'h02);

      // mode_next on a terminal-count cycle
      cyc(15);
      mode_next = 1'b1; cyc(1); mode_next = 1'b0;
      chk("coll_tick", {7'b0, tick}, 8'h00);
      chk("coll_mode", {6'b0, mode}, 8'h00);
      chk("coll_led", {4'b0, led}, 8'h01);
      cyc(15);
      chk("coll_post_hold", {7'b0, tick}, 8'h00);
      cyc(1);
      chk("coll_post_led", {4'b0, led}, 8'h02);

      // mid-operation reset from BLINK at speed 2
      mode_next = 1'b1; cyc(2); mode_next = 1'b0;
      speed_up = 1'b1; cyc(2); speed_up = 1'b0;
      chk("pre_rst_mode", {6'b0, mode}, 8'h02);
      chk("pre_rst_speed", {6'b0, speed}, 8'h02);
      chk("pre_rst_led", {4'b0, led}, 8'h0f);
      cyc(4);
      chk("blink_fast_led", {4'b0, led}, 8'h00);
      chk("blink_fast_tick", {7'b0, tick}, 8'h01);
      sys_rst = 1'b1; cyc(1); sys_rst = 1'b0;
      chk("mid_rst_led", {4'b0, led}, 8'h01);
      chk("mid_rst_mode", {6'b0, mode}, 8'h00);
      chk("mid_rst_speed", {6'b0, speed}, 8'h00);
      chk("mid_rst_tick", {7'b0, tick}, 8'h00);
      cyc(15);
      chk("mid_rst_hold", {4'b0, led}, 8'h01);
      cyc(1);
      chk("mid_rst_step", {4'b0, led}, 8'h02);
      chk("mid_rst_step_tick", {7'b0, tick}, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
